// File: rtl/tile_renderer.sv
// rtl/tile_renderer.sv - two-stage tile-grid pixel colour generator for the VGA path
// Defining GRIDLINE_EN draws GRID_COLOR on tile edges over the backdrop.
module tile_renderer #(
    parameter int          TILE         = 40,
    parameter int          COLS         = 16,
    parameter int          ROWS         = 12,
    parameter int          NUM_BULLETS  = 3,
    parameter int          ENEMY_ROWS   = 5,
    parameter int          ENEMY_COLS   = 6,
    parameter int          ENEMY_COL0   = 4,
    parameter logic [11:0] HOME_COLOR   = 12'h282,
    parameter logic [11:0] PLAYER_COLOR = 12'hFFF,
    parameter logic [11:0] GRID_COLOR   = 12'h111,
    localparam int         CW           = $clog2(COLS + 1),
    localparam int         RW           = $clog2(ROWS + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 pix_valid,
    input  logic                                 line_start,
    input  logic                                 frame_start,
    input  logic [RW-1:0]                        player_row,
    input  logic [ENEMY_ROWS*ENEMY_COLS*12-1:0]  enemy_color,
    input  logic [NUM_BULLETS*12-1:0]            bullet_color,
    input  logic [NUM_BULLETS*CW-1:0]            bullet_x,
    input  logic [NUM_BULLETS*RW-1:0]            bullet_y,
    output logic [11:0]                          rgb_out,
    output logic                                 rgb_valid
);

    localparam int             SW       = (TILE > 1) ? $clog2(TILE) : 1;
    localparam int             EW       = ENEMY_ROWS * ENEMY_COLS * 12;
    localparam logic [SW-1:0]  SUB_LAST = SW'(TILE - 1);
    localparam logic [CW-1:0]  COLS_C   = CW'(COLS);
    localparam logic [RW-1:0]  ROWS_C   = RW'(ROWS);

    logic [SW-1:0] sub_x, sub_y;
    logic [CW-1:0] tile_x;
    logic [RW-1:0] tile_y;
    logic          line_seen;

    logic [RW-1:0]               sh_player;
    logic [EW-1:0]               sh_enemy;
    logic [NUM_BULLETS*12-1:0]   sh_bcol;
    logic [NUM_BULLETS*CW-1:0]   sh_bx;
    logic [NUM_BULLETS*RW-1:0]   sh_by;

    // Coordinates of this cycle's pixel, after any strobe in the same cycle.
    logic [SW-1:0] x_sub, y_sub, x_sub_nx;
    logic [CW-1:0] x_tile, x_tile_nx;
    logic [RW-1:0] y_tile;

    always_comb begin
        x_sub  = line_start ? '0 : sub_x;
        x_tile = line_start ? '0 : tile_x;
        y_sub  = sub_y;
        y_tile = tile_y;
        if (frame_start) begin
            y_sub  = '0;
            y_tile = '0;
        end else if (line_start && line_seen) begin
            y_sub = (sub_y == SUB_LAST) ? '0 : sub_y + 1'b1;
            if (sub_y == SUB_LAST && tile_y != ROWS_C)
                y_tile = tile_y + 1'b1;
        end
        x_sub_nx  = (x_sub == SUB_LAST) ? '0 : x_sub + 1'b1;
        x_tile_nx = (x_sub == SUB_LAST && x_tile != COLS_C) ? x_tile + 1'b1 : x_tile;
    end

    logic          p_hit, b_hit, e_hit;
    logic [11:0]   b_col, e_col, src_col;
    logic [RW-1:0] e_row;
    logic [CW-1:0] e_cidx;

    always_comb begin
        p_hit = (x_tile == CW'(1)) && (y_tile == sh_player);

        // Descending scan so the lowest matching slot is the one left standing.
        b_hit = 1'b0;
        b_col = 12'h000;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (sh_bcol[i*12 +: 12] != 12'h000 && sh_bx[i*CW +: CW] == x_tile
                && sh_by[i*RW +: RW] == y_tile) begin
                b_hit = 1'b1;
                b_col = sh_bcol[i*12 +: 12];
            end
        end

        e_row  = y_tile >> 1;
        e_cidx = (x_tile - CW'(ENEMY_COL0)) >> 1;
        e_hit  = y_tile[0] && !x_tile[0] && (int'(x_tile) >= ENEMY_COL0)
                 && (int'(e_row) < ENEMY_ROWS) && (int'(e_cidx) < ENEMY_COLS);
        e_col  = 12'h000;
        for (int r = 0; r < ENEMY_ROWS; r++) begin
            for (int c = 0; c < ENEMY_COLS; c++) begin
                if (int'(e_row) == r && int'(e_cidx) == c)
                    e_col = sh_enemy[(r*ENEMY_COLS + c)*12 +: 12];
            end
        end

        src_col = b_hit ? b_col : e_col;
    end

    logic          s1_valid;
    logic [CW-1:0] s1_tile_x;
    logic [RW-1:0] s1_tile_y;
    logic [2:0]    s1_hit;
    logic [11:0]   s1_color;
    logic [11:0]   backdrop;
    logic [11:0]   pix_color;

`ifdef GRIDLINE_EN
    logic s1_grid;
    assign backdrop = s1_grid ? GRID_COLOR : 12'h000;
`else
    // Folds to zero; GRID_COLOR only matters when gridlines are built in.
    localparam logic [11:0] NO_GRID = GRID_COLOR & 12'h000;
    assign backdrop = NO_GRID;
`endif

    always_comb begin
        pix_color = 12'h000;
        if (s1_tile_x >= COLS_C || s1_tile_y >= ROWS_C)
            pix_color = 12'h000;
        else if (s1_tile_x == '0)
            pix_color = HOME_COLOR;
        else if (s1_hit[2])
            pix_color = PLAYER_COLOR;
        else if (s1_hit[1] || s1_hit[0])
            pix_color = s1_color;
        else
            pix_color = backdrop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_x     <= '0;
            sub_y     <= '0;
            tile_x    <= '0;
            tile_y    <= '0;
            line_seen <= 1'b0;
            sh_player <= '0;
            sh_enemy  <= '0;
            sh_bcol   <= '0;
            sh_bx     <= '0;
            sh_by     <= '0;
            s1_valid  <= 1'b0;
            s1_tile_x <= '0;
            s1_tile_y <= '0;
            s1_hit    <= '0;
            s1_color  <= '0;
`ifdef GRIDLINE_EN
            s1_grid   <= 1'b0;
`endif
            rgb_out   <= 12'h000;
            rgb_valid <= 1'b0;
        end else begin
            line_seen <= pix_valid | (line_seen & ~(frame_start | line_start));
            sub_y     <= y_sub;
            tile_y    <= y_tile;
            sub_x     <= pix_valid ? x_sub_nx : x_sub;
            tile_x    <= pix_valid ? x_tile_nx : x_tile;
            // The snapshot lands at the edge, so this cycle's pixel still sees the old one.
            if (frame_start) begin
                sh_player <= player_row;
                sh_enemy  <= enemy_color;
                sh_bcol   <= bullet_color;
                sh_bx     <= bullet_x;
                sh_by     <= bullet_y;
            end
            s1_valid  <= pix_valid;
            s1_tile_x <= x_tile;
            s1_tile_y <= y_tile;
            s1_hit    <= {p_hit, b_hit, e_hit};
            s1_color  <= src_col;
`ifdef GRIDLINE_EN
            s1_grid   <= (x_sub == '0) || (y_sub == '0);
`endif
            rgb_valid <= s1_valid;
            rgb_out   <= s1_valid ? pix_color : 12'h000;
        end
    end

endmodule
